// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, ALU operations,
// write-back and immediate selects, and the 4-bit state enum.
package multicycle_control_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LUI  = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_BNE  = 4'd12;
    localparam logic [3:0] OP_JAL  = 4'd13;
    localparam logic [3:0] OP_JALR = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] NB_4  = 2'd0;
    localparam logic [1:0] NB_8  = 2'd1;

    localparam logic [1:0] SH_NONE = 2'd0;
    localparam logic [1:0] SH_8    = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JUMPR  = 4'd11,
        S_HALTED = 4'd12
    } state_t;

    // Dispatch taken at the end of DECODE.
    function automatic state_t decode_next(input logic [3:0] op);
        state_t nxt;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SLL, OP_SRL:     nxt = S_EXEC_R;
            OP_ADDI, OP_LUI, OP_JALR:   nxt = S_EXEC_I;
            OP_LW, OP_SW:               nxt = S_ADDR;
            OP_BEQ, OP_BNE:             nxt = S_BRANCH;
            OP_JAL:                     nxt = S_JUMP;
            default:                    nxt = S_HALTED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_pc.sv
// Program counter register with load (priority) and increment enables.
module multicycle_control_pc #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_VALUE;
        end else if (load) begin
            pc_reg <= load_value;
        end else if (inc) begin
            pc_reg <= pc_reg + WIDTH'(1);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back
// and owns the program counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [3:0]          Op,
    input  logic                aluZero,
    input  logic [PC_WIDTH-1:0] aluResult,
    input  logic                memReady,
    output logic [PC_WIDTH-1:0] PC,
    output logic [2:0]          ALUOp,
    output logic                ALUSrcA,
    output logic                ALUSrcB,
    output logic [1:0]          immShift,
    output logic [1:0]          numBits,
    output logic                IRWrite,
    output logic                writeEnable,
    output logic [1:0]          memToReg,
    output logic                memRead,
    output logic                memWrite,
    output logic                IorD,
    output logic                halted,
    output logic [3:0]          state
);

    state_t state_reg, state_next;
    logic   pc_inc, pc_load, branch_taken;
    logic   ir_write, reg_write, mem_read, mem_write;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    assign branch_taken = (Op == OP_BNE) ? ~aluZero : aluZero;

    always_comb begin
        state_next = state_reg;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        ALUOp      = ALU_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        immShift   = SH_NONE;
        numBits    = NB_4;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        memToReg   = M2R_ALU;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        IorD       = 1'b0;
        halted     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read = 1'b1;
                if (memReady) begin
                    ir_write   = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target is computed here and parked in ALUOut.
                ALUSrcA    = 1'b1;
                ALUSrcB    = 1'b1;
                numBits    = (Op == OP_JAL) ? NB_8 : NB_4;
                state_next = decode_next(Op);
            end
            S_EXEC_R: begin
                ALUOp      = Op[2:0];
                state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrcB    = 1'b1;
                state_next = S_WB_ALU;
                if (Op == OP_LUI) begin
                    ALUOp    = ALU_PASSB;
                    numBits  = NB_8;
                    immShift = SH_8;
                end else if (Op == OP_JALR) begin
                    state_next = S_JUMPR;
                end
            end
            S_ADDR: begin
                ALUSrcB    = 1'b1;
                state_next = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
                if (memReady) state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
                if (memReady) state_next = S_FETCH;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                memToReg   = M2R_MEM;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUOp      = ALU_SUB;
                pc_load    = branch_taken;
                state_next = S_FETCH;
            end
            S_JUMP, S_JUMPR: begin
                reg_write  = 1'b1;
                memToReg   = M2R_PC;
                pc_load    = 1'b1;
                state_next = S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by reset directly so they drop without waiting for a clock.
    assign IRWrite     = ir_write  & reset;
    assign writeEnable = reg_write & reset;
    assign memRead     = mem_read  & reset;
    assign memWrite    = mem_write & reset;
    assign state       = state_reg;

    multicycle_control_pc #(
        .WIDTH       (PC_WIDTH),
        .RESET_VALUE (PC_WIDTH'(RESET_PC))
    ) u_pc (
        .clk        (CLK),
        .rst_n      (reset),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (aluResult),
        .pc         (PC)
    );

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM driving the step-2 datapath (register file, ALU, ALUOut register, instruction register, immediate generator).
- Consumes the decoded 4-bit opcode, ALU zero/result and a memory ready handshake.
- Produces per-cycle datapath strobes: ALUOp, ALUSrcA/B, IRWrite, writeEnable, immShift/numBits, and memory controls.
- Owns the program counter register (PC is an input to the datapath).

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_WIDTH, 16, PC width; only 16 is supported.

Ports:
CLK  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
Op  input  4  opcode from the instruction register.
aluZero  input  1  combinational ALU result == 0.
aluResult  input  16  registered ALUOut.
memReady  input  1  memory completes the current read/write this cycle.
PC  output  16  program counter.
ALUOp  output  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 passB.
ALUSrcA  output  1  0 = rs0 (A), 1 = PC.
ALUSrcB  output  1  0 = rs1 (B), 1 = immediate.
immShift  output  2  0 = none, 1 = <<1, 2 = <<8.
numBits  output  2  immediate width: 0 = 4b, 1 = 8b, 2 = 12b.
IRWrite  output  1  load instruction register.
writeEnable  output  1  register-file write.
memToReg  output  2  dataWrite select: 0 ALUOut, 1 memory data, 2 PC.
memRead  output  1  memory read request.
memWrite  output  1  memory write request.
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
halted  output  1  FSM is in HALTED.
state  output  4  current state encoding (debug).

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 ADDI, 8 LUI, 9 LW, 10 SW, 11 BEQ, 12 BNE, 13 JAL, 14 JALR, 15 HALT.
- Reset (reset = 0, asynchronous):
  - state <= FETCH, PC <= RESET_PC.
  - All strobes (IRWrite, writeEnable, memRead, memWrite) are forced 0 while reset is low.
  - Any in-flight memory access is abandoned.
- Outputs are combinational from state and Op.
- IRWrite and the PC update are Mealy on memReady.
- Unlisted outputs are 0 in every state.
- FETCH:
  - memRead = 1, IorD = 0.
  - Hold until memReady; then IRWrite = 1, PC <= PC + 1, go to DECODE.
- DECODE (1 cycle):
  - Precompute the target into ALUOut: ALUSrcA = 1, ALUSrcB = 1, ALUOp = add.
  - numBits = 1 for JAL, otherwise 0.
  - Next state by Op: 0–6 → EXEC_R; 7, 8, 14 → EXEC_I; 9, 10 → ADDR; 11, 12 → BRANCH; 13 → JUMP; 15 → HALTED.
- EXEC_R: ALUSrcA = 0, ALUSrcB = 0, ALUOp = Op[2:0] (Op 0–6 map to ALUOp 0–6); go to WB_ALU.
- EXEC_I: ALUSrcB = 1.
  - ADDI: add, A, numBits = 0.
  - LUI: passB, numBits = 1, immShift = 2.
  - JALR: add, A, numBits = 0, next state JUMPR.
  - Otherwise next state WB_ALU.
- ADDR: A + imm4 (numBits = 0); go to MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: memRead = 1, IorD = 1; hold until memReady, then WB_MEM.
- MEM_WR: memWrite = 1, IorD = 1; hold until memReady, then FETCH.
- WB_ALU: writeEnable = 1, memToReg = 0; go to FETCH.
- WB_MEM: writeEnable = 1, memToReg = 1; go to FETCH.
- BRANCH:
  - ALUSrcA = 0, ALUSrcB = 0, ALUOp = sub. ALUOut is not relied on; aluResult still holds the DECODE target.
  - Taken = aluZero for BEQ, ~aluZero for BNE.
  - If taken, PC <= aluResult. Go to FETCH.
- JUMP: writeEnable = 1, memToReg = 2 (rd <= PC, already +1), PC <= aluResult; go to FETCH.
- JUMPR: same as JUMP, using the EXEC_I result.
- HALTED: halted = 1, no strobes; stays until reset.
- memReady is ignored outside FETCH, MEM_RD and MEM_WR.
- PC arithmetic wraps modulo 2^16 (0xFFFF + 1 = 0x0000).
- Latency with memReady held 1: R-type/ADDI/LUI 4 cycles; LW 5; SW 4; branch 3; JAL 3; JALR 4.

Decomposition:
- Shared package: opcode constants, ALUOp constants, memToReg codes, numBits/immShift codes, state enum (4-bit).
- No sub-module required. An optional pc_register sub-module holds the PC with load/increment enables.

Test Plan:
- memReady = 1, Op = 0 (ADD): FETCH, DECODE, EXEC_R, WB_ALU.
  - IRWrite in cycle 1; PC 0x0000 → 0x0001.
  - ALUOp = 0 and ALUSrcA = ALUSrcB = 0 in cycle 3; writeEnable = 1, memToReg = 0 in cycle 4.
- Op = 9 (LW), memReady low 3 cycles in MEM_RD:
  - memRead and IorD held 1 for 4 cycles.
  - WB_MEM asserts writeEnable with memToReg = 1 exactly once.
- Op = 11 (BEQ), aluResult = 0x0010:
  - aluZero = 1 in BRANCH → PC = 0x0010.
  - Repeat with aluZero = 0 → PC = 0x0001.
- Op = 13 (JAL), aluResult = 0x0042:
  - JUMP asserts writeEnable with memToReg = 2.
  - PC = 0x0042 on the next cycle.
- Op = 15 (HALT): halted = 1; 20 further cycles show no strobes and PC unchanged.
- reset low during MEM_WR:
  - state = FETCH and PC = RESET_PC immediately.
  - memWrite drops in the same cycle.
  - After release, FETCH resumes from RESET_PC.
